// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_cmd_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = 16;
  // Enough bits to count WORD_W shifts modulo WORD_W.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_STROBE = 2'b10,
    OP_CLEAR  = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e             opcode;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } cmd_word_t;

  typedef enum logic {
    FR_IDLE  = 1'b0,
    FR_SHIFT = 1'b1
  } frame_state_e;

  // Address reported on reg_wr_addr for a register-file clear.
  localparam logic [ADDR_W-1:0] CLEAR_ADDR = 6'h3F;

endpackage

// File: rtl/spi_word_framer.sv
// Frames 16-bit SPI words: arming after reset, bit counting, capture/execute
// pipeline and partial-frame detection.
module spi_word_framer
  import spi_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ncs,
  input  logic              err_clr,
  input  logic [WORD_W-1:0] sr_q,
  output logic              sr_enable,
  output logic              word_valid,
  output cmd_word_t         word,
  output logic              err_frame
);

  frame_state_e      state_q, state_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              cap_q, cap_d;
  logic              exe_q, exe_d;
  cmd_word_t         word_q, word_d;
  logic              err_frame_q, err_frame_d;
  logic              frame_abort;

  // Shifting is only allowed once the framer has seen ncs high since reset.
  assign sr_enable = armed_q & ~spi_ncs;

  // Next-state: arm, count bits, launch capture/execute, detect aborted frames.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    bit_cnt_d   = bit_cnt_q;
    cap_d       = 1'b0;
    exe_d       = cap_q;
    word_d      = word_q;
    err_frame_d = err_frame_q;
    frame_abort = 1'b0;

    if (spi_ncs) begin
      armed_d = 1'b1;
    end

    state_d = sr_enable ? FR_SHIFT : FR_IDLE;

    if (sr_enable) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      cap_d     = (bit_cnt_q == CNT_W'(WORD_W - 1));
    end else if ((state_q == FR_SHIFT) && spi_ncs && (bit_cnt_q != '0)) begin
      frame_abort = 1'b1;
      bit_cnt_d   = '0;
    end

    // sr_q moves on the next shift, so grab it the edge after the 16th bit.
    if (cap_q) begin
      word_d = cmd_word_t'(sr_q);
    end

    // A new framing error beats a simultaneous clear.
    if (err_clr) begin
      err_frame_d = 1'b0;
    end
    if (frame_abort) begin
      err_frame_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FR_IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      cap_q       <= 1'b0;
      exe_q       <= 1'b0;
      word_q      <= '0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      cap_q       <= cap_d;
      exe_q       <= exe_d;
      word_q      <= word_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign word_valid = exe_q;
  assign word       = word_q;
  assign err_frame  = err_frame_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: frames words from the shift register and decodes
// them into register writes, strobes and register-file clears.
module spi_cmd_ctrl #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned WORD_W   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              spi_ncs,
  output logic                              sr_enable,
  input  logic [WORD_W-1:0]                 sr_q,
  output logic [NUM_REGS*8-1:0]             reg_data,
  output logic                              reg_wr_stb,
  output logic [spi_cmd_pkg::ADDR_W-1:0]    reg_wr_addr,
  output logic [NUM_REGS-1:0]               cmd_pulse,
  output logic [15:0]                       word_cnt,
  output logic                              err_addr,
  output logic                              err_frame,
  input  logic                              err_clr
);

  import spi_cmd_pkg::*;

  logic               word_valid;
  cmd_word_t          word;
  logic               addr_ok;
  logic               addr_err;

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               reg_wr_stb_q, reg_wr_stb_d;
  logic [ADDR_W-1:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [NUM_REGS-1:0] cmd_pulse_q, cmd_pulse_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic               err_addr_q, err_addr_d;

  spi_word_framer u_framer (
    .clk        (clk),
    .reset      (reset),
    .spi_ncs    (spi_ncs),
    .err_clr    (err_clr),
    .sr_q       (sr_q),
    .sr_enable  (sr_enable),
    .word_valid (word_valid),
    .word       (word),
    .err_frame  (err_frame)
  );

  assign addr_ok = (32'(word.addr) < NUM_REGS);

  // Decode an executed word into register-file and command updates.
  always_comb begin
    regs_d        = regs_q;
    reg_wr_stb_d  = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    cmd_pulse_d   = '0;
    word_cnt_d    = word_cnt_q;
    err_addr_d    = err_addr_q;
    addr_err      = 1'b0;

    if (word_valid) begin
      word_cnt_d = word_cnt_q + 16'd1;
      unique case (word.opcode)
        OP_NOP: ;
        OP_WRITE: begin
          if (addr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (ADDR_W'(i) == word.addr) begin
                regs_d[i] = word.data;
              end
            end
            reg_wr_stb_d  = 1'b1;
            reg_wr_addr_d = word.addr;
          end else begin
            addr_err = 1'b1;
          end
        end
        OP_STROBE: begin
          if (addr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (ADDR_W'(i) == word.addr) begin
                cmd_pulse_d[i] = 1'b1;
              end
            end
          end else begin
            addr_err = 1'b1;
          end
        end
        OP_CLEAR: begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = '0;
          end
          reg_wr_stb_d  = 1'b1;
          reg_wr_addr_d = CLEAR_ADDR;
        end
        default: ;
      endcase
    end

    // A new address error beats a simultaneous clear.
    if (err_clr) begin
      err_addr_d = 1'b0;
    end
    if (addr_err) begin
      err_addr_d = 1'b1;
    end
  end

  // Output and register-file flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      reg_wr_stb_q  <= 1'b0;
      reg_wr_addr_q <= '0;
      cmd_pulse_q   <= '0;
      word_cnt_q    <= '0;
      err_addr_q    <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      reg_wr_stb_q  <= reg_wr_stb_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      cmd_pulse_q   <= cmd_pulse_d;
      word_cnt_q    <= word_cnt_d;
      err_addr_q    <= err_addr_d;
    end
  end

  // Flatten the register file, reg i at [8i+7:8i].
  always_comb begin
    reg_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_data[8*i +: 8] = regs_q[i];
    end
  end

  assign reg_wr_stb  = reg_wr_stb_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign cmd_pulse   = cmd_pulse_q;
  assign word_cnt    = word_cnt_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl with a bit-level shift-register model.
module tb_spi_cmd_ctrl;

  localparam int unsigned NR = 16;
  localparam int unsigned CW = NR * 8;

  logic           clk;
  logic           reset;
  logic           spi_ncs;
  logic           sr_enable;
  logic [15:0]    sr_q;
  logic [CW-1:0]  reg_data;
  logic           reg_wr_stb;
  logic [5:0]     reg_wr_addr;
  logic [NR-1:0]  cmd_pulse;
  logic [15:0]    word_cnt;
  logic           err_addr;
  logic           err_frame;
  logic           err_clr;
  logic           mosi;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  spi_cmd_ctrl #(.NUM_REGS(NR), .WORD_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_ncs     (spi_ncs),
    .sr_enable   (sr_enable),
    .sr_q        (sr_q),
    .reg_data    (reg_data),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_addr (reg_wr_addr),
    .cmd_pulse   (cmd_pulse),
    .word_cnt    (word_cnt),
    .err_addr    (err_addr),
    .err_frame   (err_frame),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // External 16-bit shift register, MSB = first bit received.
  initial sr_q = 16'h0000;
  always @(posedge clk) if (sr_enable) sr_q <= {sr_q[14:0], mosi};

  typedef struct {
    int             exp_edge;
    logic           stb;
    logic [5:0]     waddr;
    logic [NR-1:0]  pulse;
    logic [CW-1:0]  regs;
    logic [15:0]    cnt;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state.
  bit          m_armed;
  int          m_bits;
  logic [15:0] m_word;
  logic [7:0]  m_regs [NR];
  logic [15:0] m_cnt;
  bit          m_err_a;
  bit          m_err_f;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Apply one decoded word to the model and queue the visible result.
  task automatic model_exec(input logic [15:0] w, input int at);
    ev_t        ev;
    int         op;
    int         a;
    logic [7:0] d;
    op = int'(w[15:14]);
    a  = int'(w[13:8]);
    d  = w[7:0];
    ev.exp_edge = at;
    ev.stb      = 1'b0;
    ev.waddr    = 6'd0;
    ev.pulse    = '0;
    m_cnt = m_cnt + 16'd1;
    case (op)
      1: if (a < NR) begin m_regs[a] = d; ev.stb = 1'b1; ev.waddr = 6'(a); end
         else m_err_a = 1'b1;
      2: if (a < NR) ev.pulse[a] = 1'b1;
         else m_err_a = 1'b1;
      3: begin
           for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
           ev.stb   = 1'b1;
           ev.waddr = 6'h3F;
         end
      default: ;
    endcase
    for (int i = 0; i < NR; i++) ev.regs[i*8 +: 8] = m_regs[i];
    ev.cnt = m_cnt;
    exp_q.push_back(ev);
  endtask

  // Model the effect of the upcoming clock edge given the inputs just driven.
  task automatic model_edge();
    int at;
    at = cyc + 1;
    if (reset) begin
      m_armed = 1'b0;
      m_bits  = 0;
      m_cnt   = 16'h0000;
      m_err_a = 1'b0;
      m_err_f = 1'b0;
      for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
      return;
    end
    if (err_clr) begin
      m_err_a = 1'b0;
      m_err_f = 1'b0;
    end
    if (spi_ncs) begin
      if (m_bits != 0) m_err_f = 1'b1;
      m_bits  = 0;
      m_armed = 1'b1;
    end else if (m_armed) begin
      m_word = {m_word[14:0], mosi};
      m_bits++;
      if (m_bits == 16) begin
        m_bits = 0;
        model_exec(m_word, at + 2);
      end
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; spi_ncs = 1'b1; err_clr = 1'b0; mosi = 1'b0;
      model_edge();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b0; spi_ncs = 1'b1; err_clr = 1'b0; mosi = 1'($urandom);
      model_edge();
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    reset = 1'b0; spi_ncs = 1'b0; err_clr = 1'b0; mosi = b;
    model_edge();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int b = 15; b >= 0; b--) drive_bit(w[b]);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    reset = 1'b0; spi_ncs = 1'b1; err_clr = 1'b1;
    model_edge();
    @(negedge clk);
    err_clr = 1'b0;
    model_edge();
  endtask

  // Idle until every queued execute has been observed, bounded.
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      idle(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  // Monitor: each word_cnt change is one executed word; compare to scoreboard.
  logic [15:0]   prev_cnt = 16'h0000;
  logic [CW-1:0] mon_regs = '0;

  always @(posedge clk) begin
    ev_t ev;
    #1;
    if (reset) begin
      prev_cnt = 16'h0000;
      mon_regs = '0;
    end else begin
      while (exp_q.size() != 0 && exp_q[0].exp_edge < cyc) begin
        ev = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_exec: got none at edge %0d, required word_cnt 0x%0h", ev.exp_edge, ev.cnt);
        mon_regs = ev.regs;
      end
      if (word_cnt !== prev_cnt) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_exec: got word_cnt 0x%0h, required 0x%0h", word_cnt, prev_cnt);
        end else begin
          ev = exp_q.pop_front();
          chk("exec_edge", CW'(cyc), CW'(ev.exp_edge));
          chk("reg_wr_stb", CW'(reg_wr_stb), CW'(ev.stb));
          if (ev.stb) chk("reg_wr_addr", CW'(reg_wr_addr), CW'(ev.waddr));
          chk("cmd_pulse", CW'(cmd_pulse), CW'(ev.pulse));
          chk("reg_data", reg_data, ev.regs);
          chk("word_cnt", CW'(word_cnt), CW'(ev.cnt));
          mon_regs = ev.regs;
        end
        prev_cnt = word_cnt;
      end else if (reg_wr_stb !== 1'b0 || cmd_pulse !== '0 || reg_data !== mon_regs) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_outputs: got stb=%0b pulse=0x%0h regs=0x%0h, required stb=0 pulse=0 regs=0x%0h",
                 reg_wr_stb, cmd_pulse, reg_data, mon_regs);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unarmed_bad;
    int nw;
    logic [15:0] w;
    reset = 1'b1; spi_ncs = 1'b1; err_clr = 1'b0; mosi = 1'b0;
    m_word = 16'h0000;
    reset_cycles(3);

    // Reset state.
    chk("rst_reg_data", reg_data, '0);
    chk("rst_word_cnt", CW'(word_cnt), CW'(0));
    chk("rst_reg_wr_addr", CW'(reg_wr_addr), CW'(0));
    chk("rst_cmd_pulse", CW'(cmd_pulse), CW'(0));
    chk("rst_errs", CW'({err_addr, err_frame}), CW'(0));
    chk("rst_sr_enable", CW'(sr_enable), CW'(0));
    idle(2);

    // Strobe 13.
    send_word(16'h8DF3);
    idle(1);
    drain();
    chk("strobe_word_cnt", CW'(word_cnt), CW'(1));
    chk("strobe_regs", reg_data, '0);

    // Write then clear.
    send_word(16'h4355);
    idle(2);
    drain();
    chk("write_reg3", CW'(reg_data[31:24]), CW'(8'h55));
    chk("write_addr", CW'(reg_wr_addr), CW'(3));
    send_word(16'hC000);
    drain();
    chk("clear_regs", reg_data, '0);
    chk("clear_addr", CW'(reg_wr_addr), CW'(6'h3F));

    // Back-to-back words in one frame.
    send_word(16'h4011);
    send_word(16'h4122);
    drain();
    chk("b2b_reg0", CW'(reg_data[7:0]), CW'(8'h11));
    chk("b2b_reg1", CW'(reg_data[15:8]), CW'(8'h22));

    // Out-of-range address.
    send_word(16'h5A77);
    drain();
    chk("oor_err_addr", CW'(err_addr), CW'(1));
    chk("oor_regs_kept", CW'(reg_data[7:0]), CW'(8'h11));
    pulse_err_clr();
    chk("err_clr_addr", CW'(err_addr), CW'(0));

    // Partial frame then realigned full frame.
    for (int i = 0; i < 9; i++) drive_bit(1'($urandom));
    idle(2);
    send_word(16'h4207);
    drain();
    chk("partial_err_frame", CW'(err_frame), CW'(1));
    chk("realign_reg2", CW'(reg_data[23:16]), CW'(8'h07));
    pulse_err_clr();
    chk("err_clr_frame", CW'(err_frame), CW'(0));

    // Reset mid-frame with ncs held low.
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    @(negedge clk);
    reset = 1'b1; spi_ncs = 1'b0; mosi = 1'b0;
    model_edge();
    unarmed_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sr_enable !== 1'b0) unarmed_bad++;
      reset = 1'b0; spi_ncs = 1'b0; mosi = 1'($urandom);
      model_edge();
    end
    @(negedge clk);
    if (sr_enable !== 1'b0) unarmed_bad++;
    reset = 1'b0; spi_ncs = 1'b1;
    model_edge();
    chk("unarmed_sr_enable", CW'(unarmed_bad), CW'(0));
    chk("unarmed_word_cnt", CW'(word_cnt), CW'(0));
    chk("unarmed_err_frame", CW'(err_frame), CW'(0));
    idle(1);
    send_word(16'h4401);
    drain();
    chk("rearm_reg4", CW'(reg_data[39:32]), CW'(8'h01));

    // Randomized frames, partial frames and error clears.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        nw = $urandom_range(1, 15);
        for (int i = 0; i < nw; i++) drive_bit(1'($urandom));
      end else begin
        nw = $urandom_range(1, 3);
        for (int j = 0; j < nw; j++) begin
          w = {2'($urandom_range(0, 3)), 6'($urandom_range(0, NR + 7)), 8'($urandom)};
          send_word(w);
        end
      end
      idle($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        drain();
        chk("rand_err_addr", CW'(err_addr), CW'(m_err_a));
        chk("rand_err_frame", CW'(err_frame), CW'(m_err_f));
        pulse_err_clr();
        chk("rand_clr_errs", CW'({err_addr, err_frame}), CW'({m_err_a, m_err_f}));
      end
    end
    drain();
    chk("final_err_addr", CW'(err_addr), CW'(m_err_a));
    chk("final_err_frame", CW'(err_frame), CW'(m_err_f));
    chk("final_word_cnt", CW'(word_cnt), CW'(m_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Sequencer and command decoder for the 16-bit SPI shift register that feeds the LED controller. It gates the shift-register enable from chip-select and counts bit-clocks to frame 16-bit words. It captures each completed word from the shift register and decodes it into register writes, strobe commands and register-file clears. Its outputs are the configuration register file and the command pulses consumed by the LED datapath.

Parameters:
NUM_REGS, 16, number of 8-bit configuration registers (2..64)
WORD_W, 16, SPI word width; fixed by the shift register, so only 16 is legal

Ports:
clk  in  1  system clock; SPI bits are shifted one per clk while selected
reset  in  1  synchronous, active-high reset
spi_ncs  in  1  chip select, active low, synchronous to clk
sr_enable  out  1  shift-register enable, driven to the shift register's enable input
sr_q  in  16  shift-register parallel output (MSB = first bit received)
reg_data  out  NUM_REGS*8  register file, flattened, reg i at [8i+7:8i]
reg_wr_stb  out  1  one-cycle pulse on each register write
reg_wr_addr  out  6  address of the current write
cmd_pulse  out  NUM_REGS  one-hot, one-cycle strobe outputs
word_cnt  out  16  count of words executed, wraps at 0xFFFF
err_addr  out  1  sticky: address >= NUM_REGS was received
err_frame  out  1  sticky: ncs rose with a partial word
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset values: all registers 0x00, reg_wr_stb=0, reg_wr_addr=0, cmd_pulse=0, word_cnt=0, err_*=0, bit_cnt=0, armed=0.
- Reset mid-frame: armed=0. Bits are ignored and sr_enable is held 0 until spi_ncs is sampled high once, then armed=1. This realigns the framing to the next frame.
- sr_enable is combinational: armed & !spi_ncs.
- Framing: on each clk edge with sr_enable=1, bit_cnt increments mod 16.
  - The edge where bit_cnt==15 is the 16th shift. It sets cap (registered), and bit_cnt becomes 0.
  - Back-to-back words within one ncs-low frame are legal; counting continues without a gap.
- Capture: on the edge after cap=1, word_reg <= sr_q and exe <= 1. This must happen exactly one edge after the 16th shift, because sr_q changes on the next shift.
- Execute: on the edge after exe=1, the decode takes effect, so outputs change 2 clk after the 16th shift edge.
  - Field map: opcode=word[15:14], addr=word[13:8], data=word[7:0].
  - 00 NOP: no effect except word_cnt increments.
  - 01 WRITE: if addr<NUM_REGS then reg[addr]<=data, reg_wr_stb=1, reg_wr_addr=addr.
  - 10 STROBE: if addr<NUM_REGS then cmd_pulse[addr]=1 for 1 cycle. data is ignored.
  - 11 CLEAR: all registers <=0x00. addr and data are ignored. reg_wr_stb=1 and reg_wr_addr=0x3F.
  - Out-of-range addr on WRITE or STROBE: no write or pulse, err_addr<=1.
  - word_cnt increments on every executed word, including errored ones.
- State machine (framing): IDLE (ncs high or unarmed) -> SHIFT (ncs low) -> IDLE (ncs high). cap and exe form an independent 2-stage pipeline, so an execute can overlap the next word's shifting.
- ncs rising with bit_cnt!=0: the partial word is discarded, bit_cnt<=0, err_frame<=1. A cap or exe already in flight still completes.
- err_clr simultaneous with a new error: the error wins (set has priority).
- Valid ncs timing: ncs may rise on the edge right after the 16th shift. That word is still captured and executed.

Decomposition:
- Package spi_cmd_pkg holds:
  - typedef enum logic[1:0] {OP_NOP, OP_WRITE, OP_STROBE, OP_CLEAR};
  - typedef struct packed for the word fields;
  - framing state enum;
  - constants ADDR_W=6, DATA_W=8, WORD_W=16.
- Sub-module spi_word_framer holds the arm logic, bit_cnt, sr_enable, cap/exe pipeline and err_frame detection. It outputs word_valid plus word. The decode and register file stay in the top.

Test Plan:
- Reset then frame 0x8DF3 (bits 1000 1101 1111 0011, ncs low 16 clk) -> cmd_pulse[13] high exactly 1 cycle, 2 clk after 16th shift; word_cnt=1; registers unchanged.
- Frame 0x4355 -> reg[3]=0x55, reg_wr_stb=1, reg_wr_addr=3; then frame 0xC000 -> all reg=0x00, reg_wr_addr=0x3F.
- Two words back-to-back in one frame, 0x4011 then 0x4122 (32 clk low) -> reg[0]=0x11, reg[1]=0x22, two strobes 16 clk apart.
- Frame 0x5A77 (addr 26 >= 16) -> no write, err_addr=1; err_clr pulse -> err_addr=0.
- ncs high after 9 bits, then full frame 0x4207 -> err_frame=1, partial discarded, reg[2]=0x07 (framing realigned).
- Reset asserted at bit 5 of a frame with ncs held low 20 more clk -> sr_enable stays 0, no execute; next full frame 0x4401 -> reg[4]=0x01.
